// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: one-hot arbiter state and access owner.
package memory_port_arbiter_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        OWN_C  = 4'b0010,
        OWN_D  = 4'b0100,
        LOCK_C = 4'b1000
    } arb_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_C    = 2'd1,
        OWNER_D    = 2'd2
    } arb_owner_t;

    localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/memory_port_arbiter_starvation_counter.sv
// Saturating wait counter for the D port; sat tells the arbiter D must override core priority.
module arb_starvation_counter
    import memory_port_arbiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    input  logic [WAIT_W-1:0] limit,
    output logic [WAIT_W-1:0] count,
    output logic              sat
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q < limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign sat   = (count_q >= limit);

endmodule

// File: rtl/memory_port_arbiter.sv
// Data-memory port arbiter: core (C) fixed priority with lock, DMA/debug (D) starvation override.
// Optional grant/stall statistics are built when ARB_STATS_EN is defined.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 30,
    parameter int DATA_W       = 32,
    parameter int MAX_DMA_WAIT = 8
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic                c_req,
    input  logic                c_we,
    input  logic                c_lock,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_be,
    output logic                c_gnt,
    output logic                c_rvalid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [3:0]          dbg_state,
    output logic [WAIT_W-1:0]   dbg_wait_cnt
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]         stat_c_grants,
    output logic [31:0]         stat_d_grants,
    output logic [31:0]         stat_d_stall
`endif
);

    // Handshake: a requester holds req and its fields stable until gnt; gnt is
    // combinational in the issue cycle, and a read's rvalid follows exactly one cycle later.

    arb_state_t state_q, state_d;
    arb_owner_t winner;
    logic       wait_sat;
    logic       rv_valid_q, rv_valid_d;
    logic       rv_owner_q, rv_owner_d;

    arb_starvation_counter u_wait (
        .clock (clock),
        .reset (reset),
        .inc   (d_req && !d_gnt),
        .clr   (!d_req || d_gnt),
        .limit (WAIT_W'(MAX_DMA_WAIT)),
        .count (dbg_wait_cnt),
        .sat   (wait_sat)
    );

    always_comb begin
        winner  = OWNER_NONE;
        state_d = IDLE;
        if (state_q == LOCK_C) begin
            if (c_req) winner = OWNER_C;
        end else if (d_req && wait_sat) begin
            winner = OWNER_D;
        end else if (c_req) begin
            winner = OWNER_C;
        end else if (d_req) begin
            winner = OWNER_D;
        end
        // Grants are suppressed while reset is held so every output is quiet.
        if (reset) winner = OWNER_NONE;

        case (winner)
            OWNER_C: state_d = c_lock ? LOCK_C : OWN_C;
            OWNER_D: state_d = OWN_D;
            default: state_d = ((state_q == LOCK_C) && c_lock) ? LOCK_C : IDLE;
        endcase
    end

    always_comb begin
        c_gnt     = (winner == OWNER_C);
        d_gnt     = (winner == OWNER_D);
        mem_en    = c_gnt || d_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (c_gnt) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            mem_be    = c_be;
        end else if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end
        rv_valid_d = mem_en && !mem_we;
        rv_owner_d = d_gnt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rv_valid_q <= 1'b0;
            rv_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rv_valid_q <= rv_valid_d;
            rv_owner_q <= rv_owner_d;
        end
    end

    assign c_rvalid  = rv_valid_q && !rv_owner_q;
    assign d_rvalid  = rv_valid_q && rv_owner_q;
    assign rdata     = rv_valid_q ? mem_rdata : '0;
    assign dbg_state = state_q;

`ifdef ARB_STATS_EN
    logic [31:0] stat_c_q, stat_c_d;
    logic [31:0] stat_d_q, stat_d_d;
    logic [31:0] stat_s_q, stat_s_d;

    always_comb begin
        stat_c_d = stat_c_q;
        stat_d_d = stat_d_q;
        stat_s_d = stat_s_q;
        if (c_gnt && (stat_c_q != '1)) stat_c_d = stat_c_q + 1'b1;
        if (d_gnt && (stat_d_q != '1)) stat_d_d = stat_d_q + 1'b1;
        if (d_req && !d_gnt && (stat_s_q != '1)) stat_s_d = stat_s_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_c_q <= '0;
            stat_d_q <= '0;
            stat_s_q <= '0;
        end else begin
            stat_c_q <= stat_c_d;
            stat_d_q <= stat_d_d;
            stat_s_q <= stat_s_d;
        end
    end

    assign stat_c_grants = stat_c_q;
    assign stat_d_grants = stat_d_q;
    assign stat_d_stall  = stat_s_q;
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: directed scenarios plus random traffic against a reference model.
module tb_memory_port_arbiter;
    import memory_port_arbiter_pkg::*;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int MAXW   = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              c_req = 0, c_we = 0, c_lock = 0;
    logic [ADDR_W-1:0] c_addr = '0;
    logic [DATA_W-1:0] c_wdata = '0;
    logic [BE_W-1:0]   c_be = '0;
    logic              d_req = 0, d_we = 0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [BE_W-1:0]   d_be = '0;
    logic              c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [3:0]        dbg_state;
    logic [7:0]        dbg_wait_cnt;
`ifdef ARB_STATS_EN
    logic [31:0]       stat_c_grants, stat_d_grants, stat_d_stall;
    int unsigned       s_c, s_d, s_stall;
`endif

    memory_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DMA_WAIT(MAXW)) dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
`ifdef ARB_STATS_EN
        , .stat_c_grants(stat_c_grants), .stat_d_grants(stat_d_grants), .stat_d_stall(stat_d_stall)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: priority rules, lock flag, wait count and a memory image.
    int unsigned       n_cmp = 0;
    int unsigned       n_bad = 0;
    logic [DATA_W-1:0] backend_mem [64];
    logic [DATA_W-1:0] ref_mem [64];
    logic [DATA_W:0]   exp_q [$];
    arb_state_t        m_state;
    int                m_wait;
    bit                c_pend, d_pend;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_state = IDLE;
        m_wait  = 0;
        c_pend  = 0;
        d_pend  = 0;
        exp_q.delete();
`ifdef ARB_STATS_EN
        s_c = 0; s_d = 0; s_stall = 0;
`endif
    endtask

    task automatic set_idle();
        c_req = 0; c_lock = 0; d_req = 0;
    endtask

    // Called at a negedge with inputs driven; checks this cycle, advances to the next negedge.
    task automatic step();
        bit                ec, ed, erv, eown, w_we, a_en, a_we;
        logic [DATA_W-1:0] erd, w_wdata, a_wdata;
        logic [ADDR_W-1:0] w_addr, a_addr;
        logic [BE_W-1:0]   w_be, a_be;
        logic [DATA_W:0]   e;
        #1;
        erv = 0; eown = 0; erd = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            erv = 1; eown = e[DATA_W]; erd = e[DATA_W-1:0];
        end
        check_eq("c_rvalid", 64'(c_rvalid), 64'(erv && !eown));
        check_eq("d_rvalid", 64'(d_rvalid), 64'(erv && eown));
        check_eq("rdata", 64'(rdata), 64'(erd));
        check_eq("state", 64'(dbg_state), 64'(m_state));
        check_eq("wait_cnt", 64'(dbg_wait_cnt), 64'(m_wait));
`ifdef ARB_STATS_EN
        check_eq("stat_c", 64'(stat_c_grants), 64'(s_c));
        check_eq("stat_d", 64'(stat_d_grants), 64'(s_d));
        check_eq("stat_stall", 64'(stat_d_stall), 64'(s_stall));
`endif
        ec = 0; ed = 0;
        if (m_state == LOCK_C) ec = c_req;
        else if (d_req && m_wait == MAXW) ed = 1;
        else if (c_req) ec = 1;
        else if (d_req) ed = 1;
        w_we = 0; w_addr = '0; w_wdata = '0; w_be = '0;
        if (ec) begin w_we = c_we; w_addr = c_addr; w_wdata = c_wdata; w_be = c_be; end
        if (ed) begin w_we = d_we; w_addr = d_addr; w_wdata = d_wdata; w_be = d_be; end
        check_eq("c_gnt", 64'(c_gnt), 64'(ec));
        check_eq("d_gnt", 64'(d_gnt), 64'(ed));
        check_eq("mem_en", 64'(mem_en), 64'(ec || ed));
        check_eq("mem_we", 64'(mem_we), 64'(w_we));
        check_eq("mem_addr", 64'(mem_addr), 64'(w_addr));
        check_eq("mem_wdata", 64'(mem_wdata), 64'(w_wdata));
        check_eq("mem_be", 64'(mem_be), 64'(w_be));
        if ((ec || ed) && !w_we) exp_q.push_back({ed, ref_mem[w_addr[5:0]]});
        a_en = mem_en; a_we = mem_we; a_addr = mem_addr; a_wdata = mem_wdata; a_be = mem_be;
        @(posedge clock);
        if (a_en) begin
            if (a_we) begin
                for (int b = 0; b < BE_W; b++)
                    if (a_be[b]) backend_mem[a_addr[5:0]][b*8 +: 8] = a_wdata[b*8 +: 8];
            end else begin
                mem_rdata = backend_mem[a_addr[5:0]];
            end
        end
        if ((ec || ed) && w_we)
            for (int b = 0; b < BE_W; b++)
                if (w_be[b]) ref_mem[w_addr[5:0]][b*8 +: 8] = w_wdata[b*8 +: 8];
`ifdef ARB_STATS_EN
        if (ec) s_c++;
        if (ed) s_d++;
        if (d_req && !ed) s_stall++;
`endif
        if (ed || !d_req) m_wait = 0;
        else if (m_wait < MAXW) m_wait++;
        if (ec) m_state = c_lock ? LOCK_C : OWN_C;
        else if (ed) m_state = OWN_D;
        else m_state = (m_state == LOCK_C && c_lock) ? LOCK_C : IDLE;
        if (ec) c_pend = 0;
        if (ed) d_pend = 0;
        @(negedge clock);
    endtask

    task automatic drive_random();
        if (!c_pend && $urandom_range(0, 3) != 0) begin
            c_pend = 1; c_we = 1'($urandom_range(0, 1)); c_addr = 30'($urandom_range(0, 63));
            c_wdata = $urandom; c_be = 4'($urandom_range(1, 15));
        end else if (c_pend && $urandom_range(0, 15) == 0) begin
            c_pend = 0;
        end
        c_req  = c_pend;
        c_lock = c_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        if (!d_pend && $urandom_range(0, 1) == 0) begin
            d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = 30'($urandom_range(0, 63));
            d_wdata = $urandom; d_be = 4'($urandom_range(1, 15));
        end else if (d_pend && $urandom_range(0, 19) == 0) begin
            d_pend = 0;
        end
        d_req = d_pend;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            backend_mem[i] = $urandom;
            ref_mem[i] = backend_mem[i];
        end
        backend_mem[16] = 32'hDEADBEEF;
        ref_mem[16]     = 32'hDEADBEEF;
        model_reset();

        // Reset held: everything quiet even with a request present.
        @(negedge clock);
        d_req = 1;
        #1;
        check_eq("rst_d_gnt", 64'(d_gnt), 64'(0));
        check_eq("rst_mem_en", 64'(mem_en), 64'(0));
        check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clock);
        set_idle();
        reset = 0;

        // Idle for five cycles.
        for (int i = 0; i < 5; i++) step();

        // C read of 0x10.
        c_req = 1; c_we = 0; c_addr = 30'h10; c_be = 4'hF; c_lock = 0;
        step();
        set_idle();
        #1;
        check_eq("c_read_rdata", 64'(rdata), 64'(32'hDEADBEEF));
        check_eq("c_read_d_rvalid", 64'(d_rvalid), 64'(0));
        step();

        // Starvation: both requesting continuously.
        c_req = 1; c_we = 0; c_addr = 30'h1;
        d_req = 1; d_we = 0; d_addr = 30'h2; d_be = 4'hF;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("starve_d_gnt", 64'(d_gnt), 64'(i == 8));
            step();
        end
        set_idle();
        step();

        // Lock: preload read locks the port, D saturates but stays blocked.
        c_req = 1; c_we = 0; c_addr = 30'h5; c_lock = 1; d_req = 1;
        step();
        c_req = 0;
        for (int i = 0; i < 9; i++) begin
            #1;
            check_eq("lock_d_blocked", 64'(d_gnt), 64'(0));
            step();
        end
        check_eq("lock_wait_sat", 64'(dbg_wait_cnt), 64'(MAXW));
        c_req = 1; c_we = 1; c_addr = 30'h5; c_be = 4'b0010; c_wdata = 32'h0000AB00; c_lock = 0;
        #1;
        check_eq("lock_store_gnt", 64'(c_gnt), 64'(1));
        step();
        c_req = 0;
        #1;
        check_eq("lock_d_after", 64'(d_gnt), 64'(1));
        step();
        set_idle();
        step();

        // Reset during LOCK_C with a read rvalid pending.
        c_req = 1; c_we = 0; c_addr = 30'h7; c_lock = 1;
        step();
        c_req = 0; d_req = 1; d_we = 0; d_addr = 30'h9;
        reset = 1;
        #1;
        check_eq("rstmid_c_rvalid", 64'(c_rvalid), 64'(0));
        check_eq("rstmid_mem_en", 64'(mem_en), 64'(0));
        check_eq("rstmid_rdata", 64'(rdata), 64'(0));
        check_eq("rstmid_state", 64'(dbg_state), 64'(IDLE));
        model_reset();
        @(negedge clock);
        c_lock = 0;
        reset = 0;
        #1;
        check_eq("rstmid_d_first", 64'(d_gnt), 64'(1));
        step();
        set_idle();
        step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
        end
        set_idle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
